gpio_button_conditioner: RTL and testbench
==========================================

# gpio_button_conditioner

Parametrised button input conditioner for the board top level. It replaces the inline inversion of raw push-buttons into the GPIO input vector. Each button input goes through per-button polarity handling, a two-flop synchronizer and a counter-based debouncer. Debounced press/release edges are delivered as events on an AXI-Stream-style FIFO output, and level outputs keep feeding the existing GPIO input vector.

## Interface
Parameters:
- NUM_BUTTONS, 5, number of button inputs (1..32)
- ACTIVE_LOW_MASK, 5'b11111, bit i = 1: button i is pressed when its pin is 0
- DEBOUNCE_CYCLES, 36000, stable cycles needed before accepting a change (1 ms at 36 MHz); ≥ 2
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥ 2
- REPEAT_DELAY, 18000000, hold cycles before the first auto-repeat (only with the macro)
- REPEAT_PERIOD, 3600000, cycles between auto-repeats (only with the macro)

Ports:
- clock  in  1  single clock domain
- reset  in  1  asynchronous, active-high reset
- button_in  in  NUM_BUTTONS  raw pins, asynchronous to clock
- button_level  out  NUM_BUTTONS  debounced state, 1 = pressed
- event_tdata  out  IW+2  {repeat, press, index[IW-1:0]}; IW = max(1, $clog2(NUM_BUTTONS))
- event_tvalid  out  1  FIFO head valid
- event_tready  in  1  consumer accepts the head
- overflow  out  1  sticky: an event was lost
- overflow_clear  in  1  clears overflow

## Operation
- Polarity: pressed_raw[i] = button_in[i] XOR ACTIVE_LOW_MASK[i].
- Synchronizer: two flops per button. Reset value: inactive (0 after the polarity XOR).
- Debouncer, per button, with counter width $clog2(DEBOUNCE_CYCLES):
  - synced == button_level: counter cleared to 0.
  - synced != button_level and counter == DEBOUNCE_CYCLES-1: button_level toggles and the counter clears.
  - Otherwise the counter increments.
- Edge capture: a toggle of button_level sets pending[i] and records pend_press[i] = new level.
  - Another toggle while pending[i] is set: pend_press[i] is overwritten with the new level, and overflow is set (an edge was lost).
- Arbiter: each cycle the lowest index i with pending[i] set is chosen when the FIFO is not full. It writes {0, pend_press[i], i} and clears pending[i].
  - At most one write per cycle.
  - Higher-indexed pending buttons wait.
  - When the FIFO is full, all pending bits are held. This alone is not an overflow.
- Event FIFO: synchronous circular buffer with DEPTH entries and pointers one bit wider than the address.
  - event_tvalid = not empty.
  - A pop happens when event_tvalid && event_tready.
  - A push and a pop in the same cycle are allowed when full. Full status is evaluated before the pop, so a push into a full FIFO waits even if a pop occurs that cycle.
- Overflow: set on a lost edge. overflow_clear clears it. If set and clear occur in the same cycle, set wins.
- Reset (asynchronous, any time, including mid-debounce or with the FIFO occupied):
  - all counters, pending bits, FIFO pointers and the repeat state return to 0;
  - button_level = 0, event_tvalid = 0, overflow = 0;
  - event_tdata = 0.

## Timing
- A pin change held stable reaches button_level exactly 2 + DEBOUNCE_CYCLES cycles later.
- A glitch shorter than DEBOUNCE_CYCLES synced cycles produces no change and no event.
- Edge to event: button_level toggles at edge T. pending is set at T+1. With the FIFO empty, the write happens at T+1 and event_tvalid is high after T+2.
- With the FIFO empty, N simultaneous edges produce N consecutive writes in ascending index order.
- event_tdata is stable while event_tvalid && !event_tready.
- A FIFO holding DEPTH entries with event_tready held high drains at one entry per cycle.

## Configuration
- GPIO_COND_REPEAT_EN defined:
  - Each button has a hold counter. It starts on a press and clears on a release or a reset.
  - The counter reaching REPEAT_DELAY, then every further REPEAT_PERIOD cycles, raises a repeat request.
  - Repeat requests use the pending path with repeat = 1 and press = 1.
  - A repeat request while pending[i] is already set is dropped silently. It does not set overflow.
- GPIO_COND_REPEAT_EN undefined:
  - No hold counters are present.
  - The repeat bit of event_tdata is constant 0.

## Test plan
- Test parameters: DEBOUNCE_CYCLES=8, FIFO_DEPTH=4. The checks:
- Reset: button_in = 5'b11111 through reset -> after release, button_level=0, event_tvalid=0, no events for 100 cycles.
- Button 2 pin driven low and held -> button_level[2]=1 exactly 10 cycles later, event_tvalid 2 cycles after that, tdata = {0,1,3'd2}. Pin released -> release event {0,0,3'd2}.
- Button 1 glitched low for 5 cycles -> no button_level change, no event.
- Buttons 0, 3 and 4 pressed in the same cycle, tready=1 -> events for indices 0, 3, 4 on consecutive cycles, each with press=1.
- tready=0, then five press/release edges on button 0 -> 4 events in the FIFO. A further edge while pending sets overflow. overflow_clear then returns overflow to 0.
- With GPIO_COND_REPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=10, button 1 held -> repeat events {1,1,3'd1} at 20 and 30 cycles after the press event.

Source files
------------

// File: rtl/gpio_button_conditioner.sv
// Button conditioner: polarity fix, two-flop synchronizer and counter debounce per button,
// with debounced edges queued as events. Define GPIO_COND_REPEAT_EN to add hold auto-repeat.
module gpio_button_conditioner #(
  parameter int NUM_BUTTONS = 5,
  parameter logic [NUM_BUTTONS-1:0] ACTIVE_LOW_MASK = {NUM_BUTTONS{1'b1}},
  parameter int DEBOUNCE_CYCLES = 36000,
  parameter int FIFO_DEPTH = 4,
  parameter int REPEAT_DELAY = 18000000,
  parameter int REPEAT_PERIOD = 3600000,
  localparam int IW = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] button_in,
  output logic [NUM_BUTTONS-1:0] button_level,
  output logic [IW+1:0]          event_tdata,
  output logic                   event_tvalid,
  input  logic                   event_tready,
  output logic                   overflow,
  input  logic                   overflow_clear
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (NUM_BUTTONS < 1 || NUM_BUTTONS > 32 || DEBOUNCE_CYCLES < 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("gpio_button_conditioner: invalid parameter set");
  end

  logic [NUM_BUTTONS-1:0] sync_p0, sync_p1;
  logic [CW-1:0]          db_cnt [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] level_prev, lvl_edge;
  logic [NUM_BUTTONS-1:0] pending, pend_press, grant, rep_req, rep_take;
  logic [IW-1:0]          grant_idx;
  logic                   grant_vld, lost;
  logic [IW+1:0]          fifo_mem [FIFO_DEPTH];
  logic [IW+1:0]          fifo_wdata;
  logic [AW:0]            wptr, rptr;
  logic                   fifo_full, fifo_empty, pop;

  // Stage p0/p1: synchronizer, reset to the inactive (not pressed) state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= button_in ^ ACTIVE_LOW_MASK;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: level follows sync_p1 only after DEBOUNCE_CYCLES consecutive mismatching samples
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BUTTONS; i++) db_cnt[i] <= '0;
      button_level <= '0;
      level_prev   <= '0;
    end else begin
      level_prev <= button_level;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (sync_p1[i] == button_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          button_level[i] <= ~button_level[i];
          db_cnt[i]       <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign lvl_edge = button_level ^ level_prev;

`ifdef GPIO_COND_REPEAT_EN
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HCW  = $clog2(HMAX + 1);

  logic [HCW-1:0]         hold_cnt [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] rep_phase, pend_rep;

  always_comb begin
    rep_req = '0;
    for (int i = 0; i < NUM_BUTTONS; i++)
      rep_req[i] = button_level[i] && (rep_phase[i] ? (hold_cnt[i] == HCW'(REPEAT_PERIOD))
                                                    : (hold_cnt[i] == HCW'(REPEAT_DELAY)));
  end

  // hold_cnt counts cycles since the press; after the first repeat it counts the period instead
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BUTTONS; i++) hold_cnt[i] <= '0;
      rep_phase <= '0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (!button_level[i]) begin
          hold_cnt[i]  <= '0;
          rep_phase[i] <= 1'b0;
        end else if (rep_req[i]) begin
          hold_cnt[i]  <= HCW'(1);
          rep_phase[i] <= 1'b1;
        end else begin
          hold_cnt[i] <= hold_cnt[i] + HCW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (lvl_edge[i]) pend_rep[i] <= 1'b0;
      else if (rep_take[i]) pend_rep[i] <= 1'b1;
    end
  end

  assign fifo_wdata = {pend_rep[grant_idx], pend_press[grant_idx], grant_idx};
`else
  assign rep_req    = '0;
  assign fifo_wdata = {1'b0, pend_press[grant_idx], grant_idx};
`endif

  // A repeat only lands in an empty slot (or one being drained this cycle); real edges win
  assign rep_take = rep_req & ~lvl_edge & (~pending | grant);
  assign lost     = |(lvl_edge & pending & ~grant);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    if (!fifo_full) begin
      for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
        if (pending[i]) begin
          grant     = '0;
          grant[i]  = 1'b1;
          grant_idx = IW'(i);
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (lvl_edge[i] || rep_take[i]) pending[i] <= 1'b1;
        else if (grant[i]) pending[i] <= 1'b0;
      end
      if (lost) overflow <= 1'b1;
      else if (overflow_clear) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (lvl_edge[i]) pend_press[i] <= button_level[i];
      else if (rep_take[i]) pend_press[i] <= 1'b1;
    end
  end

  // Event FIFO: full is judged before the pop, so a push into a full FIFO waits a cycle
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop        = !fifo_empty && event_tready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (grant_vld) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (grant_vld) fifo_mem[wptr[AW-1:0]] <= fifo_wdata;
  end

  assign event_tvalid = !fifo_empty;
  assign event_tdata  = fifo_empty ? '0 : fifo_mem[rptr[AW-1:0]];

endmodule

// File: tb/tb_gpio_button_conditioner.sv
// Self-checking bench for gpio_button_conditioner: directed scenarios plus randomized pins
// compared every cycle against a behavioural event model.
module tb_gpio_button_conditioner;

  localparam int NB    = 5;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int RD    = 20;
  localparam int RP    = 10;
  localparam logic [NB-1:0] MASK = 5'b11111;

  logic          clock = 1'b0;
  logic          reset;
  logic [NB-1:0] button_in;
  logic [NB-1:0] button_level;
  logic [4:0]    event_tdata;
  logic          event_tvalid;
  logic          event_tready;
  logic          overflow;
  logic          overflow_clear;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  gpio_button_conditioner #(
    .NUM_BUTTONS(NB), .ACTIVE_LOW_MASK(MASK), .DEBOUNCE_CYCLES(DB),
    .FIFO_DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock), .reset(reset), .button_in(button_in), .button_level(button_level),
    .event_tdata(event_tdata), .event_tvalid(event_tvalid), .event_tready(event_tready),
    .overflow(overflow), .overflow_clear(overflow_clear)
  );

  always #5 clock = ~clock;

  // Reference model: pressed samples reach the debouncer two clocks late; a level flips once
  // the last DB samples all disagree with it; edges queue one clock later, lowest index first.
  logic [NB-1:0] m_s_old, m_s_new, m_level, m_tog, m_pend, m_pp, m_pr;
  logic [DB-1:0] m_hist [NB];
  logic [4:0]    m_q [$];
  logic          m_ovf;
  int            m_age [NB];

  task automatic model_reset();
    m_s_old = '0; m_s_new = '0; m_level = '0; m_tog = '0;
    m_pend = '0; m_pp = '0; m_pr = '0; m_ovf = 1'b0;
    m_q.delete();
    for (int i = 0; i < NB; i++) begin
      m_hist[i] = '0;
      m_age[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [NB-1:0] s, lvl_pre, tog_pre, ntog, rep;
    int g;
    bit lost;
    if (reset) begin
      model_reset();
      return;
    end
    s = m_s_old; m_s_old = m_s_new; m_s_new = button_in ^ MASK;
    lvl_pre = m_level; tog_pre = m_tog;
    g = -1;
    if (m_q.size() < DEPTH)
      for (int i = NB - 1; i >= 0; i--) if (m_pend[i]) g = i;
    rep = '0;
`ifdef GPIO_COND_REPEAT_EN
    for (int i = 0; i < NB; i++) begin
      rep[i] = lvl_pre[i] && (m_age[i] >= RD) && (((m_age[i] - RD) % RP) == 0);
      m_age[i] = lvl_pre[i] ? m_age[i] + 1 : 0;
    end
`endif
    if (event_tready && m_q.size() > 0) void'(m_q.pop_front());
    if (g >= 0) m_q.push_back({m_pr[g], m_pp[g], 3'(g)});
    lost = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (tog_pre[i]) begin
        if (m_pend[i] && g != i) lost = 1'b1;
        m_pend[i] = 1'b1; m_pp[i] = lvl_pre[i]; m_pr[i] = 1'b0;
      end else if (rep[i] && (!m_pend[i] || g == i)) begin
        m_pend[i] = 1'b1; m_pp[i] = 1'b1; m_pr[i] = 1'b1;
      end else if (g == i) begin
        m_pend[i] = 1'b0;
      end
    end
    if (lost) m_ovf = 1'b1;
    else if (overflow_clear) m_ovf = 1'b0;
    for (int i = 0; i < NB; i++) begin
      m_hist[i] = {m_hist[i][DB-2:0], s[i]};
      ntog[i] = (m_hist[i] == {DB{~lvl_pre[i]}});
    end
    m_level = lvl_pre ^ ntog;
    m_tog = ntog;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic settle();
    button_in = '1; event_tready = 1'b1; overflow_clear = 1'b0;
    repeat (30) tick();
  endtask

  task automatic test_reset();
    bit seen;
    button_in = '1; event_tready = 1'b0; overflow_clear = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checks++; if (button_level !== 5'b0) begin errors++; $display("FAIL reset_level: got %b expected 00000", button_level); end
    checks++; if (event_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", event_tvalid); end
    checks++; if (event_tdata !== 5'b0) begin errors++; $display("FAIL reset_tdata: got %b expected 00000", event_tdata); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (event_tvalid !== 1'b0 || button_level !== 5'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_quiet: activity=%b expected 0", seen); end
  endtask

  task automatic test_press_release();
    event_tready = 1'b0;
    button_in[2] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 9) begin checks++; if (button_level[2] !== 1'b0) begin errors++; $display("FAIL press_early: level2=%b expected 0", button_level[2]); end end
      if (k == 10) begin checks++; if (button_level[2] !== 1'b1) begin errors++; $display("FAIL press_level: level2=%b expected 1", button_level[2]); end end
      if (k == 11) begin checks++; if (event_tvalid !== 1'b0) begin errors++; $display("FAIL press_tvalid_early: got %b expected 0", event_tvalid); end end
      if (k == 12) begin
        checks++; if (event_tvalid !== 1'b1) begin errors++; $display("FAIL press_tvalid: got %b expected 1", event_tvalid); end
        checks++; if (event_tdata !== 5'b01010) begin errors++; $display("FAIL press_tdata: got %b expected 01010", event_tdata); end
      end
    end
    tick();
    checks++; if (event_tdata !== 5'b01010) begin errors++; $display("FAIL press_hold_tdata: got %b expected 01010", event_tdata); end
    event_tready = 1'b1;
    tick();
    event_tready = 1'b0;
    checks++; if (event_tvalid !== 1'b0) begin errors++; $display("FAIL press_pop: tvalid=%b expected 0", event_tvalid); end
    button_in[2] = 1'b1;
    repeat (12) tick();
    checks++; if (button_level[2] !== 1'b0) begin errors++; $display("FAIL release_level: level2=%b expected 0", button_level[2]); end
    checks++; if (event_tvalid !== 1'b1 || event_tdata !== 5'b00010) begin
      errors++; $display("FAIL release_event: tvalid=%b tdata=%b expected 1/00010", event_tvalid, event_tdata);
    end
    settle();
  endtask

  task automatic test_glitch();
    bit bad;
    bad = 1'b0;
    button_in[1] = 1'b0;
    repeat (5) begin tick(); if (button_level[1] !== 1'b0 || event_tvalid !== 1'b0) bad = 1'b1; end
    button_in[1] = 1'b1;
    repeat (20) begin tick(); if (button_level[1] !== 1'b0 || event_tvalid !== 1'b0) bad = 1'b1; end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL glitch: activity=%b expected 0", bad); end
  endtask

  task automatic test_simultaneous();
    logic [4:0] got [$];
    int at [$];
    logic [4:0] exp_ev [3];
    exp_ev = '{5'b01000, 5'b01011, 5'b01100};
    event_tready = 1'b1;
    button_in[0] = 1'b0; button_in[3] = 1'b0; button_in[4] = 1'b0;
    for (int k = 0; k < 40 && got.size() < 3; k++) begin
      if (event_tvalid) begin got.push_back(event_tdata); at.push_back(cyc); end
      tick();
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL simul_count: got %0d expected 3", got.size()); end
    for (int j = 0; j < got.size() && j < 3; j++) begin
      checks++; if (got[j] !== exp_ev[j]) begin errors++; $display("FAIL simul_tdata%0d: got %b expected %b", j, got[j], exp_ev[j]); end
      if (j > 0) begin
        checks++; if (at[j] != at[j-1] + 1) begin errors++; $display("FAIL simul_spacing%0d: gap %0d expected 1", j, at[j] - at[j-1]); end
      end
    end
    settle();
  endtask

  task automatic test_overflow();
    logic [4:0] got [$];
    int at [$];
    logic [4:0] exp_ev [5];
    exp_ev = '{5'b01000, 5'b00000, 5'b01000, 5'b00000, 5'b00000};
    event_tready = 1'b0;
    for (int e = 0; e < 5; e++) begin
      button_in[0] = e[0];
      repeat (12) tick();
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_full_only: got %b expected 0", overflow); end
    checks++; if (event_tvalid !== 1'b1 || event_tdata !== 5'b01000) begin
      errors++; $display("FAIL ovf_head: tvalid=%b tdata=%b expected 1/01000", event_tvalid, event_tdata);
    end
    button_in[0] = 1'b1;
    overflow_clear = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 10) begin checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", overflow); end end
      if (k == 11) begin checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", overflow); end end
      if (k == 12) begin checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end end
    end
    overflow_clear = 1'b0;
    event_tready = 1'b1;
    for (int k = 0; k < 30 && got.size() < 5; k++) begin
      if (event_tvalid) begin got.push_back(event_tdata); at.push_back(cyc); end
      tick();
    end
    checks++; if (got.size() != 5) begin errors++; $display("FAIL drain_count: got %0d expected 5", got.size()); end
    for (int j = 0; j < got.size() && j < 5; j++) begin
      checks++; if (got[j] !== exp_ev[j]) begin errors++; $display("FAIL drain_tdata%0d: got %b expected %b", j, got[j], exp_ev[j]); end
      if (j > 0) begin
        checks++; if (at[j] != at[j-1] + 1) begin errors++; $display("FAIL drain_rate%0d: gap %0d expected 1", j, at[j] - at[j-1]); end
      end
    end
    settle();
  endtask

`ifdef GPIO_COND_REPEAT_EN
  task automatic test_repeat();
    logic [4:0] got [$];
    int at [$];
    event_tready = 1'b1;
    button_in[1] = 1'b0;
    for (int k = 0; k < 80 && got.size() < 3; k++) begin
      if (event_tvalid) begin got.push_back(event_tdata); at.push_back(cyc); end
      tick();
    end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL repeat_count: got %0d expected 3", got.size()); end
    if (got.size() == 3) begin
      checks++; if (got[0] !== 5'b01001) begin errors++; $display("FAIL repeat_press: got %b expected 01001", got[0]); end
      checks++; if (got[1] !== 5'b11001 || at[1] - at[0] != 20) begin
        errors++; $display("FAIL repeat_first: got %b at +%0d expected 11001 at +20", got[1], at[1] - at[0]);
      end
      checks++; if (got[2] !== 5'b11001 || at[2] - at[0] != 30) begin
        errors++; $display("FAIL repeat_second: got %b at +%0d expected 11001 at +30", got[2], at[2] - at[0]);
      end
    end
    settle();
  endtask
`endif

  task automatic test_reset_midflight();
    event_tready = 1'b0;
    button_in[3] = 1'b0; button_in[4] = 1'b0;
    repeat (14) tick();
    button_in[0] = 1'b0;
    repeat (4) tick();
    checks++; if (event_tvalid !== 1'b1) begin errors++; $display("FAIL midflight_pre: tvalid=%b expected 1", event_tvalid); end
    reset = 1'b1;
    #1;
    checks++; if (button_level !== 5'b0 || event_tvalid !== 1'b0 || event_tdata !== 5'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL midflight_async: level=%b tvalid=%b tdata=%b ovf=%b expected all 0",
                         button_level, event_tvalid, event_tdata, overflow);
    end
    tick();
    reset = 1'b0;
    event_tready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      checks++; if (button_level !== m_level) begin errors++; $display("FAIL midflight_level cyc=%0d: got %b expected %b", cyc, button_level, m_level); end
    end
    settle();
  endtask

  task automatic test_random();
    int hold_left [NB];
    logic [4:0] exp_td;
    for (int i = 0; i < NB; i++) hold_left[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (hold_left[i] == 0) begin
          button_in[i] = 1'($urandom_range(0, 1));
          hold_left[i] = $urandom_range(1, 14);
        end else begin
          hold_left[i]--;
        end
      end
      event_tready   = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      overflow_clear = ($urandom_range(0, 15) == 0);
      if (c == 1200) begin
        reset = 1'b1;
        #1;
        checks++; if (button_level !== 5'b0 || event_tvalid !== 1'b0 || overflow !== 1'b0) begin
          errors++; $display("FAIL rand_async_reset: level=%b tvalid=%b ovf=%b expected 0", button_level, event_tvalid, overflow);
        end
      end
      tick();
      reset = 1'b0;
      exp_td = (m_q.size() > 0) ? m_q[0] : 5'd0;
      checks++; if (button_level !== m_level) begin errors++; $display("FAIL rand_level cyc=%0d: got %b expected %b", cyc, button_level, m_level); end
      checks++; if (event_tvalid !== (m_q.size() > 0)) begin errors++; $display("FAIL rand_tvalid cyc=%0d: got %b expected %b", cyc, event_tvalid, m_q.size() > 0); end
      checks++; if (event_tdata !== exp_td) begin errors++; $display("FAIL rand_tdata cyc=%0d: got %b expected %b", cyc, event_tdata, exp_td); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow cyc=%0d: got %b expected %b", cyc, overflow, m_ovf); end
    end
    settle();
  endtask

  initial begin
    reset = 1'b1;
    button_in = '1;
    event_tready = 1'b0;
    overflow_clear = 1'b0;
    model_reset();
    test_reset();
    test_press_release();
    test_glitch();
    test_simultaneous();
    test_overflow();
`ifdef GPIO_COND_REPEAT_EN
    test_repeat();
`endif
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
